// File: rtl/sdram_dma_pkg.sv
// Shared types and constants for the SDRAM burst DMA engine.
// The descriptor length field is 32 bits wide so it can carry any LEN_W up to 32.
package sdram_dma_pkg;

  localparam int ADDR_W     = 24;
  localparam int DATA_W     = 16;
  localparam int DESC_LEN_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WR_FETCH,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_DONE
  } dma_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [DESC_LEN_W-1:0] len;
    logic                  rw;
  } dma_desc_t;

endpackage

// File: rtl/dma_sync_fifo.sv
// Single-clock show-ahead FIFO: the head word is always visible on head.
// Push while full and pop while empty are ignored.
module dma_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage is reset so the head word reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_dma_engine.sv
// Burst sequencer: splits a descriptor into single-word SDRAM controller requests,
// buffering read words in a show-ahead FIFO and fetching write words from a stream.
module sdram_dma_engine
  import sdram_dma_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_rw,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              done,
  output logic              active,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  output logic              mem_start,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_busy,
  input  logic              mem_complete
);

  dma_state_t                  state;
  dma_state_t                  next_state;
  dma_desc_t                   desc;
  logic [LEN_W-1:0]            remaining;
  logic                        accept;
  logic                        wr_beat;
  logic                        word_done;
  logic                        last_word;
  logic                        fifo_push;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;

  assign desc      = '{addr: cmd_addr, len: DESC_LEN_W'(cmd_len), rw: cmd_rw};
  assign accept    = cmd_valid & cmd_ready;
  assign wr_beat   = wr_valid & wr_ready;
  assign word_done = mem_complete & ((state == S_RD_WAIT) | (state == S_WR_WAIT));
  assign last_word = (remaining <= LEN_W'(1));
  assign done      = (state == S_DONE);
  assign active    = (state != S_IDLE);
  assign rd_valid  = ~fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // A read is only issued when the FIFO has room, so every completion has a slot.
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    mem_start  = 1'b0;
    fifo_push  = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (desc.len == '0) next_state = S_DONE;
          else if (desc.rw)   next_state = S_RD_ISSUE;
          else                next_state = S_WR_FETCH;
        end
      end
      S_RD_ISSUE: begin
        mem_start = ~mem_busy & ~fifo_full;
        if (mem_start) next_state = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_complete) begin
          fifo_push  = 1'b1;
          next_state = last_word ? S_DONE : S_RD_ISSUE;
        end
      end
      S_WR_FETCH: begin
        wr_ready = 1'b1;
        if (wr_valid) next_state = S_WR_ISSUE;
      end
      S_WR_ISSUE: begin
        mem_start = ~mem_busy;
        if (mem_start) next_state = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (mem_complete) next_state = last_word ? S_DONE : S_WR_FETCH;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Request fields only move on accept, a write beat, or after a completion,
  // which keeps them stable for the whole start..complete window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_rw    <= 1'b0;
      mem_wdata <= '0;
      remaining <= '0;
    end else begin
      if (accept) begin
        mem_addr  <= desc.addr;
        mem_rw    <= desc.rw;
        remaining <= desc.len[LEN_W-1:0];
      end
      if (wr_beat) mem_wdata <= wr_data;
      if (word_done) begin
        mem_addr <= mem_addr + 1'b1;
        if (remaining != '0) remaining <= remaining - 1'b1;
      end
    end
  end

  dma_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (mem_rdata),
    .pop       (rd_valid & rd_ready),
    .head      (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_fifo_count)
  );

endmodule

// File: tb/tb_sdram_dma_engine.sv
// Scoreboard bench for sdram_dma_engine: stimulus queues expected requests and
// read words, a negedge monitor pops and compares as the DUT presents them.
module tb_sdram_dma_engine;
  import sdram_dma_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = 16;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [23:0]   cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          cmd_rw;
  logic          rd_valid;
  logic          rd_ready;
  logic [15:0]   rd_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [15:0]   wr_data;
  logic          done;
  logic          active;
  logic [23:0]   mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_rw;
  logic          mem_start;
  logic [15:0]   mem_rdata;
  logic          mem_busy;
  logic          mem_complete;
  logic          model_busy;
  logic          force_busy;

  assign mem_busy = model_busy | force_busy;

  sdram_dma_engine #(.FIFO_DEPTH(DEPTH), .LEN_W(LW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .cmd_rw       (cmd_rw),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .done         (done),
    .active       (active),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rw       (mem_rw),
    .mem_start    (mem_start),
    .mem_rdata    (mem_rdata),
    .mem_busy     (mem_busy),
    .mem_complete (mem_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] addr;
    logic        rw;
    logic [15:0] wdata;
  } start_t;

  start_t      exp_start_q[$];
  logic [15:0] exp_rd_q[$];
  int check_count = 0;
  int pass_count  = 0;
  int start_count = 0;
  int done_count  = 0;
  int cyc = 0;
  int last_complete_cyc = 0;
  int done_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Memory model: read data is the word address low half plus 0x1000.
  int          mdl_cnt;
  logic        mdl_pending;
  logic [23:0] cap_addr;
  logic [15:0] cap_wdata;
  logic        cap_rw;
  logic        stable_ok;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_pending  <= 1'b0;
      model_busy   <= 1'b0;
      mem_complete <= 1'b0;
      mem_rdata    <= '0;
      mdl_cnt      <= 0;
      stable_ok    <= 1'b1;
    end else begin
      mem_complete <= 1'b0;
      if (mdl_pending) begin
        if (mem_addr !== cap_addr || mem_wdata !== cap_wdata || mem_rw !== cap_rw) stable_ok <= 1'b0;
        if (mdl_cnt == 1) begin
          mem_complete <= 1'b1;
          mem_rdata    <= cap_addr[15:0] + 16'h1000;
          model_busy   <= 1'b0;
          mdl_pending  <= 1'b0;
        end
        mdl_cnt <= mdl_cnt - 1;
      end else if (mem_start) begin
        mdl_pending <= 1'b1;
        model_busy  <= 1'b1;
        mdl_cnt     <= 5;
        cap_addr    <= mem_addr;
        cap_wdata   <= mem_wdata;
        cap_rw      <= mem_rw;
        stable_ok   <= 1'b1;
      end
    end
  end

  // Monitor: compares every request strobe and every read-stream pop.
  always @(negedge clk) begin
    start_t e;
    logic [15:0] d;
    if (rst_n) begin
      if (mem_start) begin
        start_count++;
        if (exp_start_q.size() == 0) checkOutput("unexpected_start", 32'd1, 32'd0);
        else begin
          e = exp_start_q.pop_front();
          checkOutput("start_addr", 32'(mem_addr), 32'(e.addr));
          checkOutput("start_rw", 32'(mem_rw), 32'(e.rw));
          if (!e.rw) checkOutput("start_wdata", 32'(mem_wdata), 32'(e.wdata));
        end
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd_q.size() == 0) checkOutput("unexpected_rd", 32'd1, 32'd0);
        else begin
          d = exp_rd_q.pop_front();
          checkOutput("rd_data", 32'(rd_data), 32'(d));
        end
      end
      if (mem_complete) begin
        last_complete_cyc = cyc;
        checkOutput("req_stable", 32'(stable_ok), 32'd1);
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  task automatic applyStimulus(input logic [23:0] addr, input logic [LW-1:0] len, input logic rw);
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_rw    = rw;
    cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        return;
      end
    end
    checkOutput("cmd_accept_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [15:0] data);
    wr_data  = data;
    wr_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wr_ready) begin
        @(posedge clk);
        #1 wr_valid = 1'b0;
        return;
      end
    end
    checkOutput("wr_beat_timeout", 32'd0, 32'd1);
    wr_valid = 1'b0;
  endtask

  task automatic waitDone(input int target);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done_count >= target) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    checkOutput("done_timeout", 32'(done_count), 32'(target));
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300; i++) begin
      if (exp_rd_q.size() == 0) return;
      @(posedge clk);
      #1;
    end
    checkOutput("drain_timeout", 32'(exp_rd_q.size()), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
    checkOutput({tag, "_wr_ready"},  32'(wr_ready),  32'd0);
    checkOutput({tag, "_done"},      32'(done),      32'd0);
    checkOutput({tag, "_active"},    32'(active),    32'd0);
    checkOutput({tag, "_mem_start"}, 32'(mem_start), 32'd0);
    checkOutput({tag, "_mem_rw"},    32'(mem_rw),    32'd0);
    checkOutput({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    checkOutput({tag, "_rd_data"},   32'(rd_data),   32'd0);
    checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  function automatic start_t mkStart(input logic [23:0] a, input logic rw, input logic [15:0] wd);
    start_t s;
    s.addr  = a;
    s.rw    = rw;
    s.wdata = wd;
    return s;
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0;
    int d0;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_len    = '0;
    cmd_rw     = 1'b0;
    rd_ready   = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = '0;
    force_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 checkResetValues("rst0");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] read len 4 at 0x000100");
    s0 = start_count;
    d0 = done_count;
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_start_q.push_back(mkStart(24'h000100 + 24'(i), 1'b1, 16'h0));
    exp_rd_q.push_back(16'h1100);
    exp_rd_q.push_back(16'h1101);
    exp_rd_q.push_back(16'h1102);
    exp_rd_q.push_back(16'h1103);
    applyStimulus(24'h000100, 16'd4, 1'b1);
    checkOutput("t1_first_start", 32'(mem_start), 32'd1);
    checkOutput("t1_first_addr", 32'(mem_addr), 32'h100);
    waitDone(d0 + 1);
    waitDrain();
    checkOutput("t1_starts", 32'(start_count - s0), 32'd4);
    checkOutput("t1_done_pulses", 32'(done_count - d0), 32'd1);
    checkOutput("t1_done_latency", 32'(done_cyc - last_complete_cyc), 32'd1);

    $display("[TB] read len 8 with stalled consumer");
    rd_ready = 1'b0;
    s0 = start_count;
    d0 = done_count;
    for (int i = 0; i < 8; i++) begin
      exp_start_q.push_back(mkStart(24'h000200 + 24'(i), 1'b1, 16'h0));
      exp_rd_q.push_back(16'h1200 + 16'(i));
    end
    applyStimulus(24'h000200, 16'd8, 1'b1);
    repeat (60) @(posedge clk);
    #1;
    checkOutput("t2_starts_while_full", 32'(start_count - s0), 32'd4);
    checkOutput("t2_start_blocked", 32'(mem_start), 32'd0);
    checkOutput("t2_rd_valid", 32'(rd_valid), 32'd1);
    checkOutput("t2_head", 32'(rd_data), 32'h1200);
    rd_ready = 1'b1;
    waitDone(d0 + 1);
    waitDrain();
    checkOutput("t2_starts", 32'(start_count - s0), 32'd8);
    checkOutput("t2_done_latency", 32'(done_cyc - last_complete_cyc), 32'd1);

    $display("[TB] write len 3 across address wrap");
    s0 = start_count;
    d0 = done_count;
    exp_start_q.push_back(mkStart(24'hFFFFFE, 1'b0, 16'h00A1));
    exp_start_q.push_back(mkStart(24'hFFFFFF, 1'b0, 16'h00A2));
    exp_start_q.push_back(mkStart(24'h000000, 1'b0, 16'h00A3));
    applyStimulus(24'hFFFFFE, 16'd3, 1'b0);
    checkOutput("t3_wr_ready", 32'(wr_ready), 32'd1);
    sendWord(16'h00A1);
    sendWord(16'h00A2);
    sendWord(16'h00A3);
    waitDone(d0 + 1);
    checkOutput("t3_starts", 32'(start_count - s0), 32'd3);
    checkOutput("t3_final_addr", 32'(mem_addr), 32'h000001);
    checkOutput("t3_done_latency", 32'(done_cyc - last_complete_cyc), 32'd1);

    $display("[TB] zero-length descriptor");
    s0 = start_count;
    d0 = done_count;
    applyStimulus(24'h001234, 16'd0, 1'b1);
    checkOutput("t4_done_t1", 32'(done), 32'd1);
    checkOutput("t4_cmd_ready_t1", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("t4_done_t2", 32'(done), 32'd0);
    checkOutput("t4_cmd_ready_t2", 32'(cmd_ready), 32'd1);
    checkOutput("t4_no_start", 32'(start_count - s0), 32'd0);
    checkOutput("t4_done_pulses", 32'(done_count - d0), 32'd1);

    $display("[TB] controller busy after reset");
    rst_n = 1'b0;
    exp_start_q.delete();
    exp_rd_q.delete();
    force_busy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    s0 = start_count;
    d0 = done_count;
    exp_start_q.push_back(mkStart(24'h000300, 1'b1, 16'h0));
    exp_start_q.push_back(mkStart(24'h000301, 1'b1, 16'h0));
    exp_rd_q.push_back(16'h1300);
    exp_rd_q.push_back(16'h1301);
    applyStimulus(24'h000300, 16'd2, 1'b1);
    repeat (18) @(posedge clk);
    #1;
    checkOutput("t5_no_start_busy", 32'(start_count - s0), 32'd0);
    checkOutput("t5_active", 32'(active), 32'd1);
    force_busy = 1'b0;
    #1 checkOutput("t5_start_on_release", 32'(mem_start), 32'd1);
    waitDone(d0 + 1);
    waitDrain();
    checkOutput("t5_starts", 32'(start_count - s0), 32'd2);

    $display("[TB] reset during read wait");
    rd_ready = 1'b0;
    s0 = start_count;
    for (int i = 0; i < 4; i++) begin
      exp_start_q.push_back(mkStart(24'h000400 + 24'(i), 1'b1, 16'h0));
      exp_rd_q.push_back(16'h1400 + 16'(i));
    end
    applyStimulus(24'h000400, 16'd4, 1'b1);
    for (int i = 0; i < 200 && (start_count - s0) < 3; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t6_third_start", 32'(start_count - s0), 32'd3);
    checkOutput("t6_words_queued", 32'(rd_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_start_q.delete();
    exp_rd_q.delete();
    checkResetValues("rst1");
    @(posedge clk);
    #1 rst_n = 1'b1;
    d0 = done_count;
    exp_start_q.push_back(mkStart(24'h000500, 1'b0, 16'hBEEF));
    applyStimulus(24'h000500, 16'd1, 1'b0);
    checkOutput("t6_accept_after_reset", 32'(active), 32'd1);
    sendWord(16'hBEEF);
    waitDone(d0 + 1);
    checkOutput("t6_done_pulses", 32'(done_count - d0), 32'd1);
    checkOutput("t6_rd_empty", 32'(rd_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/sdram_dma_engine.md
# sdram_dma_engine

Burst sequencer sitting directly upstream of the single-word SDRAM controller. It accepts a descriptor (start address, word count, direction) and breaks it into consecutive single-word controller requests. For reads, returned words are buffered into a small show-ahead FIFO and streamed to the MobileNet datapath over valid/ready. For writes, words are taken from a valid/ready stream and written one per request.

## Interface
- `FIFO_DEPTH`, default 16: read FIFO depth in words; must be a power of two, ≥2.
- `LEN_W`, default 16: width of the descriptor word count.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: descriptor offered.
- `cmd_ready` out 1: descriptor accepted when `cmd_valid & cmd_ready`.
- `cmd_addr` in 24: start word address.
- `cmd_len` in LEN_W: number of words; 0 is legal.
- `cmd_rw` in 1: 1 = read, 0 = write.
- `rd_valid` out 1: read-stream word available.
- `rd_ready` in 1: read-stream consumer ready.
- `rd_data` out 16: read-stream word.
- `wr_valid` in 1: write-stream word offered.
- `wr_ready` out 1: write-stream word accepted.
- `wr_data` in 16: write-stream word.
- `done` out 1: one-cycle pulse when a descriptor finishes.
- `active` out 1: high whenever the engine is not IDLE.
- `mem_addr` out 24: controller address.
- `mem_wdata` out 16: controller write data.
- `mem_rw` out 1: controller direction.
- `mem_start` out 1: controller request strobe.
- `mem_rdata` in 16: controller read data.
- `mem_busy` in 1: controller busy.
- `mem_complete` in 1: controller one-cycle completion pulse.

## Operation
- States:
  - IDLE → RD_ISSUE / WR_FETCH / DONE (len 0) on descriptor accept.
  - RD_ISSUE → RD_WAIT on `mem_start`.
  - RD_WAIT → RD_ISSUE / DONE on `mem_complete`.
  - WR_FETCH → WR_ISSUE on a `wr_valid & wr_ready` beat.
  - WR_ISSUE → WR_WAIT on `mem_start`.
  - WR_WAIT → WR_FETCH / DONE on `mem_complete`.
  - DONE → IDLE unconditionally.
- Descriptor handling:
  - `cmd_ready` = (state == IDLE), including immediately after reset.
  - On accept, `cmd_addr`, `cmd_len` and `cmd_rw` are latched into the address register and remaining-count register.
- Request issue:
  - At most one controller request is outstanding.
  - `mem_start` = (state is RD_ISSUE or WR_ISSUE) & !`mem_busy`. In RD_ISSUE it is additionally gated by FIFO not full.
  - `mem_start` is combinational and high for exactly one cycle per request.
- Held request fields:
  - `mem_addr`, `mem_rw` and `mem_wdata` are registered.
  - They are stable from the `mem_start` cycle through the `mem_complete` cycle. The controller drives `mem_wdata` live, so it must not change earlier.
- Read completion: in RD_WAIT, `mem_complete` pushes `mem_rdata` into the FIFO. Space is guaranteed by the issue gating. The remaining count decrements and the address increments.
- Write fetch:
  - `wr_ready` = (state == WR_FETCH).
  - A beat loads `mem_wdata`.
  - `mem_complete` in WR_WAIT decrements the remaining count and increments the address.
- Address arithmetic: increment is modulo 2^24, so 0xFFFFFF is followed by 0x000000. The remaining count never underflows.
- Completion: `done` = (state == DONE). For reads it fires once the last word is in the FIFO; words may still be draining.
- FIFO:
  - Show-ahead: `rd_valid` = !empty and `rd_data` = head word.
  - Pop on `rd_valid & rd_ready`.
  - Simultaneous push and pop leaves the count unchanged.
  - The FIFO is not flushed between descriptors.
- Spurious `mem_complete` outside RD_WAIT/WR_WAIT is ignored.

## Timing
- Reset values:
  - State IDLE; FIFO empty.
  - `rd_valid`, `wr_ready`, `done`, `active`, `mem_start`, `mem_rw` = 0.
  - `mem_addr`, `mem_wdata`, `rd_data` = 0.
  - `cmd_ready` = 1.
- Reset mid-operation clears all state immediately and abandons any outstanding request. The top level resets the controller from the same source, inverted.
- Accept at cycle T → ISSUE/FETCH state at T+1. The earliest `mem_start` is at T+1.
- A zero-length descriptor accepted at T gives `done` at T+1 and `cmd_ready` again at T+2, with no `mem_start`.
- Last `mem_complete` at cycle C → `done` at C+1.
- Throughput is one word per controller round trip plus one issue cycle. After a complete, `mem_start` waits for `mem_busy` to fall.

## Structure
- `sdram_dma_pkg` holds:
  - the state enum;
  - the constants ADDR_W=24 and DATA_W=16;
  - the descriptor struct (addr, len, rw).
- One sub-module, `dma_sync_fifo`: parameterised width and depth, show-ahead, with full/empty and count outputs.

## Test plan
- Read, len 4 at 0x000100, `rd_ready`=1, memory model completing 5 cycles after start → 4 `mem_start` pulses at 0x100–0x103; `rd_data` matches the model sequence; one `done` pulse.
- Read, len 8, FIFO_DEPTH=4, `rd_ready`=0 → exactly 4 starts, then no `mem_start` while full; raising `rd_ready` → remaining 4 words, all 8 delivered in order.
- Write, len 3 at 0xFFFFFE, data 0x00A1/0x00A2/0x00A3 → addresses 0xFFFFFE, 0xFFFFFF, 0x000000; `mem_wdata` stable from start to complete.
- `cmd_len`=0 accepted at T → `done` at T+1, no `mem_start`, `cmd_ready` at T+2.
- `mem_busy` held high for 20 cycles after reset with a descriptor pending → no `mem_start` until `mem_busy` falls, then a normal sequence.
- `rst_n` pulsed low during RD_WAIT with 2 words queued → all outputs at reset values and FIFO empty; a new descriptor is accepted after release.
